// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pops the async FIFO into a framed valid/ready stream
// through a two-entry skid buffer, so the pop strobe never depends on m_ready.
module fifo_rd_stream #(
    parameter int DSIZE   = 8,
    parameter int PKT_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             enable,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CNT_W-1:0] pkt_cnt
);
    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t             occ, occ_nxt;
    logic [DSIZE-1:0] head_data, skid_data;
    logic             head_last, skid_last;
    logic [IDX_W-1:0] widx;
    logic             push, pop, push_last;

    // Pop strobe uses only registered occupancy and rempty, never m_ready.
    assign rinc      = enable & ~rempty & (occ != TWO);
    assign push      = rinc;
    assign pop       = m_valid & m_ready;
    assign push_last = (widx == LAST_IDX);
    assign m_valid   = (occ != EMPTY);
    assign m_data    = head_data;
    assign m_last    = head_last;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) occ <= EMPTY;
        else         occ <= occ_nxt;
    end

    // NOTE: occ_nxt is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        occ_nxt = occ;
        case (occ)
            EMPTY: if (push) occ_nxt = ONE;
            ONE: begin
                if (push && !pop)      occ_nxt = TWO;
                else if (!push && pop) occ_nxt = EMPTY;
            end
            TWO:     if (pop) occ_nxt = ONE;
            default: occ_nxt = EMPTY;
        endcase
    end

    // NOTE: both buffer entries are reset because m_data/m_last must read 0 out of reset.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            head_data <= '0;
            head_last <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
        end else begin
            case (occ)
                EMPTY: begin
                    if (push) begin
                        head_data <= rdata;
                        head_last <= push_last;
                    end
                end
                ONE: begin
                    // Simultaneous push and pop replaces the head in place.
                    if (push && pop) begin
                        head_data <= rdata;
                        head_last <= push_last;
                    end else if (push) begin
                        skid_data <= rdata;
                        skid_last <= push_last;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_data <= skid_data;
                        head_last <= skid_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // Word index follows pushes, so framing survives enable gaps.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)   widx <= '0;
        else if (push) widx <= push_last ? '0 : widx + IDX_W'(1);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)                pkt_cnt <= '0;
        else if (pop && head_last)  pkt_cnt <= pkt_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based FIFO model, scoreboard monitor
// and per-scenario tasks; a second instance covers PKT_LEN=1 with a 2-bit counter.
module tb_fifo_rd_stream;
    logic       rclk = 1'b0;
    logic       rrst_n;
    logic [7:0] rdata = '0, rdata_w = '0;
    logic       rempty = 1'b1, rempty_w = 1'b1;
    logic       rinc, rinc_w;
    logic       enable, en_w;
    logic [7:0] m_data, m_data_w;
    logic       m_valid, m_valid_w, m_last, m_last_w;
    logic       m_ready, ready_w;
    logic [15:0] pkt_cnt;
    logic [1:0]  pkt_cnt_w;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] fifo_w[$];
    logic [7:0] exp_q[$];

    fifo_rd_stream #(.DSIZE(8), .PKT_LEN(4), .CNT_W(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
        .enable(enable), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .pkt_cnt(pkt_cnt)
    );

    fifo_rd_stream #(.DSIZE(8), .PKT_LEN(1), .CNT_W(2)) dut_w (
        .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata_w), .rempty(rempty_w), .rinc(rinc_w),
        .enable(en_w), .m_data(m_data_w), .m_valid(m_valid_w), .m_last(m_last_w),
        .m_ready(ready_w), .pkt_cnt(pkt_cnt_w)
    );

    always #5 rclk = ~rclk;

    // FIFO read-port model: head word visible whenever the registered empty flag is low.
    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            fifo_q.delete();
            fifo_w.delete();
            rempty   <= 1'b1;
            rempty_w <= 1'b1;
            rdata    <= '0;
            rdata_w  <= '0;
        end else begin
            if (rinc && fifo_q.size() > 0) fifo_q.delete(0);
            if (rinc_w && fifo_w.size() > 0) fifo_w.delete(0);
            rempty   <= (fifo_q.size() == 0);
            rdata    <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
            rempty_w <= (fifo_w.size() == 0);
            rdata_w  <= (fifo_w.size() > 0) ? fifo_w[0] : 8'h00;
        end
    end

    // Scoreboard monitor for the PKT_LEN=4 instance, sampled 3 ns after the falling edge.
    int         occ_m, beat_idx, pkt_m;
    bit         hold_p;
    logic [7:0] hold_d, exp_d;
    logic       hold_l;
    bit         beat;

    initial begin
        occ_m = 0; beat_idx = 0; pkt_m = 0; hold_p = 0; hold_d = '0; hold_l = 1'b0;
        forever begin
            @(negedge rclk);
            #3;
            if (!rrst_n) begin
                occ_m = 0; beat_idx = 0; pkt_m = 0; hold_p = 0;
                exp_q.delete();
            end else begin
                n_checks++;
                if (m_valid !== (occ_m != 0)) begin
                    n_errors++;
                    $display("FAIL mon_valid t=%0t: got %b expected %b", $time, m_valid, occ_m != 0);
                end
                n_checks++;
                if (rinc !== (enable && !rempty && occ_m < 2)) begin
                    n_errors++;
                    $display("FAIL mon_rinc t=%0t: got %b expected %b", $time, rinc, enable && !rempty && occ_m < 2);
                end
                n_checks++;
                if (pkt_cnt !== 16'(pkt_m)) begin
                    n_errors++;
                    $display("FAIL mon_pkt_cnt t=%0t: got %0d expected %0d", $time, pkt_cnt, pkt_m);
                end
                if (hold_p) begin
                    n_checks++;
                    if (m_valid !== 1'b1 || m_data !== hold_d || m_last !== hold_l) begin
                        n_errors++;
                        $display("FAIL mon_hold t=%0t: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                                 $time, m_valid, m_data, m_last, hold_d, hold_l);
                    end
                end
                beat = m_valid && m_ready;
                if (beat) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL mon_extra t=%0t: got word %h expected none", $time, m_data);
                    end else begin
                        exp_d = exp_q.pop_front();
                        if (m_data !== exp_d) begin
                            n_errors++;
                            $display("FAIL mon_data t=%0t: got %h expected %h", $time, m_data, exp_d);
                        end
                    end
                    n_checks++;
                    if (m_last !== (beat_idx == 3)) begin
                        n_errors++;
                        $display("FAIL mon_last t=%0t: got %b expected %b", $time, m_last, beat_idx == 3);
                    end
                    if (beat_idx == 3) pkt_m++;
                    beat_idx = (beat_idx + 1) % 4;
                end
                hold_p = m_valid && !m_ready;
                hold_d = m_data;
                hold_l = m_last;
                occ_m  = occ_m + (rinc ? 1 : 0) - (beat ? 1 : 0);
            end
        end
    end

    task automatic write_word(input logic [7:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst_n = 1'b0;
        @(negedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({m_valid, m_last, m_data, rinc, pkt_cnt} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h rinc=%b cnt=%0d expected all 0",
                     m_valid, m_last, m_data, rinc, pkt_cnt);
        end
        n_checks++;
        if ({m_valid_w, m_last_w, m_data_w, rinc_w, pkt_cnt_w} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs_w: got v=%b l=%b d=%h rinc=%b cnt=%0d expected all 0",
                     m_valid_w, m_last_w, m_data_w, rinc_w, pkt_cnt_w);
        end
    endtask

    task automatic test_stream();
        int nb = 0, first_v = -1, last_v = -1, first_r = -1;
        enable  = 1'b1;
        m_ready = 1'b1;
        @(negedge rclk);
        for (int i = 0; i < 12; i++) write_word(8'(i));
        for (int c = 0; c < 60 && nb < 12; c++) begin
            @(negedge rclk);
            #3;
            if (rinc && first_r < 0) first_r = c;
            if (m_valid && m_ready) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                n_checks++;
                if (m_data !== 8'(nb) || m_last !== (nb % 4 == 3)) begin
                    n_errors++;
                    $display("FAIL stream_beat%0d: got d=%h l=%b expected d=%h l=%b",
                             nb, m_data, m_last, 8'(nb), nb % 4 == 3);
                end
                nb++;
            end
        end
        @(negedge rclk);
        #3;
        n_checks++;
        if (nb != 12) begin
            n_errors++;
            $display("FAIL stream_count: got %0d expected 12", nb);
        end
        n_checks++;
        if (first_v != first_r + 1) begin
            n_errors++;
            $display("FAIL stream_latency: got valid cycle %0d expected %0d", first_v, first_r + 1);
        end
        n_checks++;
        if (last_v - first_v != 11) begin
            n_errors++;
            $display("FAIL stream_rate: got span %0d expected 11", last_v - first_v);
        end
        n_checks++;
        if (pkt_cnt !== 16'd3) begin
            n_errors++;
            $display("FAIL stream_pkt_cnt: got %0d expected 3", pkt_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        bit seen = 0;
        m_ready = 1'b0;
        enable  = 1'b1;
        @(negedge rclk);
        for (int i = 0; i < 4; i++) write_word(8'hA0 + 8'(i));
        repeat (4) @(negedge rclk);
        #3;
        n_checks++;
        if (m_valid !== 1'b1 || rinc !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_full: got v=%b rinc=%b expected v=1 rinc=0", m_valid, rinc);
        end
        #1 rrst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_valid, m_last, m_data, rinc, pkt_cnt} !== '0) begin
            n_errors++;
            $display("FAIL midreset_async: got v=%b l=%b d=%h rinc=%b cnt=%0d expected all 0",
                     m_valid, m_last, m_data, rinc, pkt_cnt);
        end
        @(negedge rclk);
        @(negedge rclk);
        rrst_n  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) write_word(8'hB0 + 8'(i));
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge rclk);
            #3;
            if (m_valid) begin
                seen = 1;
                n_checks++;
                if (m_data !== 8'hB0 || m_last !== 1'b0 || pkt_cnt !== 16'd0) begin
                    n_errors++;
                    $display("FAIL midreset_first: got d=%h l=%b cnt=%0d expected d=b0 l=0 cnt=0",
                             m_data, m_last, pkt_cnt);
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL midreset_timeout: got no beat expected one within 20 cycles");
        end
        repeat (8) @(negedge rclk);
    endtask

    task automatic test_backpressure();
        int pulses = 0, nb = 0, first_b = -1, last_b = -1;
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_word(8'h40 + 8'(i));
        for (int c = 0; c < 10; c++) begin
            @(negedge rclk);
            #3;
            if (rinc) pulses++;
            if (m_valid) begin
                n_checks++;
                if (m_data !== 8'h40) begin
                    n_errors++;
                    $display("FAIL bp_stable c=%0d: got %h expected 40", c, m_data);
                end
            end
        end
        n_checks++;
        if (pulses != 2 || rinc !== 1'b0 || m_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_fill: got pulses=%0d rinc=%b v=%b expected pulses=2 rinc=0 v=1",
                     pulses, rinc, m_valid);
        end
        for (int c = 0; c < 20 && nb < 8; c++) begin
            @(negedge rclk);
            m_ready = 1'b1;
            #3;
            if (c < 2) begin
                n_checks++;
                if (rinc !== (c == 1)) begin
                    n_errors++;
                    $display("FAIL bp_rinc_resume c=%0d: got %b expected %b", c, rinc, c == 1);
                end
            end
            if (m_valid && m_ready) begin
                if (first_b < 0) first_b = c;
                last_b = c;
                n_checks++;
                if (m_data !== 8'h40 + 8'(nb)) begin
                    n_errors++;
                    $display("FAIL bp_order%0d: got %h expected %h", nb, m_data, 8'h40 + 8'(nb));
                end
                nb++;
            end
        end
        n_checks++;
        if (nb != 8 || first_b != 0 || last_b != 7) begin
            n_errors++;
            $display("FAIL bp_drain: got n=%0d first=%0d last=%0d expected n=8 first=0 last=7",
                     nb, first_b, last_b);
        end
    endtask

    task automatic test_enable();
        int  pushes = 0, hold = 0, nb = 0;
        bit  chk_pkt = 0;
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) write_word(8'(i));
        for (int c = 0; c < 40 && nb < 8; c++) begin
            @(negedge rclk);
            if (pushes >= 3 && hold < 5) begin
                enable = 1'b0;
                hold++;
            end else begin
                enable = 1'b1;
            end
            #3;
            if (!enable) begin
                n_checks++;
                if (rinc !== 1'b0) begin
                    n_errors++;
                    $display("FAIL en_rinc_off c=%0d: got %b expected 0", c, rinc);
                end
            end
            if (!enable && hold == 5) begin
                n_checks++;
                if (m_valid !== 1'b0 || nb != 3) begin
                    n_errors++;
                    $display("FAIL en_drain: got v=%b beats=%0d expected v=0 beats=3", m_valid, nb);
                end
            end
            if (chk_pkt) begin
                chk_pkt = 0;
                n_checks++;
                if (pkt_cnt !== 16'd1) begin
                    n_errors++;
                    $display("FAIL en_pkt_cnt: got %0d expected 1", pkt_cnt);
                end
            end
            if (rinc) pushes++;
            if (m_valid && m_ready) begin
                if (m_data == 8'h03) begin
                    chk_pkt = 1;
                    n_checks++;
                    if (m_last !== 1'b1) begin
                        n_errors++;
                        $display("FAIL en_last3: got %b expected 1", m_last);
                    end
                end
                nb++;
            end
        end
        n_checks++;
        if (nb != 8) begin
            n_errors++;
            $display("FAIL en_count: got %0d expected 8", nb);
        end
        enable = 1'b1;
    endtask

    task automatic test_wrap();
        int nb = 0;
        ready_w = 1'b1;
        en_w    = 1'b1;
        @(negedge rclk);
        for (int i = 0; i < 5; i++) fifo_w.push_back(8'h60 + 8'(i));
        for (int c = 0; c < 40 && nb < 5; c++) begin
            @(negedge rclk);
            #3;
            n_checks++;
            if (pkt_cnt_w !== 2'(nb)) begin
                n_errors++;
                $display("FAIL wrap_cnt c=%0d: got %0d expected %0d", c, pkt_cnt_w, 2'(nb));
            end
            if (m_valid_w) begin
                n_checks++;
                if (m_data_w !== 8'h60 + 8'(nb) || m_last_w !== 1'b1) begin
                    n_errors++;
                    $display("FAIL wrap_beat%0d: got d=%h l=%b expected d=%h l=1",
                             nb, m_data_w, m_last_w, 8'h60 + 8'(nb));
                end
                nb++;
            end
        end
        @(negedge rclk);
        #3;
        n_checks++;
        if (nb != 5 || pkt_cnt_w !== 2'd1) begin
            n_errors++;
            $display("FAIL wrap_final: got beats=%0d cnt=%0d expected beats=5 cnt=1", nb, pkt_cnt_w);
        end
        en_w = 1'b0;
    endtask

    task automatic test_random();
        int written = 0, nb = 0;
        for (int c = 0; c < 20000 && nb < 1000; c++) begin
            @(negedge rclk);
            m_ready = 1'($urandom % 2);
            enable  = ($urandom % 10) != 0;
            if (written < 1000 && ($urandom % 2) == 1) begin
                write_word(8'($urandom));
                written++;
            end
            #3;
            if (m_valid && m_ready) nb++;
        end
        @(negedge rclk);
        #3;
        n_checks++;
        if (nb != 1000 || exp_q.size() != 0 || m_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL random_done: got beats=%0d left=%0d v=%b expected beats=1000 left=0 v=0",
                     nb, exp_q.size(), m_valid);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rrst_n  = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        en_w    = 1'b0;
        ready_w = 1'b0;
        #1 rrst_n = 1'b0;
        #1;
        test_reset();
        @(negedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
        test_stream();
        test_reset_midstream();
        test_backpressure();
        test_enable();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the asynchronous FIFO. It sits entirely in the read clock domain, pops words from the FIFO read port (`rdata`, `rempty`, `rinc`), and presents them downstream as a valid/ready stream with packet framing. A 2-entry skid buffer keeps `rinc` free of any combinational path from `m_ready`.

## Interface
Parameters:
- `DSIZE`, 8, data width; matches the FIFO data width.
- `PKT_LEN`, 16, words per packet. `m_last` marks every `PKT_LEN`-th word. Legal range is 1 to 2^16.
- `CNT_W`, 16, width of the completed-packet counter.

Ports:
- `rclk`  in  1  read-domain clock. This is the only clock.
- `rrst_n`  in  1  reset, asynchronous, active-low.
- `rdata`  in  DSIZE  FIFO head word. It is valid in any cycle where `rempty`=0 (combinational memory read at the current read address).
- `rempty`  in  1  FIFO empty flag, registered in the `rclk` domain.
- `rinc`  out  1  FIFO pop strobe. The head word is consumed on each `rclk` edge where `rinc`=1.
- `enable`  in  1  allows new pops. Words already buffered are still delivered when `enable`=0.
- `m_data`  out  DSIZE  stream data.
- `m_valid`  out  1  stream valid.
- `m_last`  out  1  final word of the current packet.
- `m_ready`  in  1  downstream accept.
- `pkt_cnt`  out  CNT_W  count of completed packets (a `m_last` beat accepted).

## Operation
- Buffer: two entries, head and skid, each holding {data, last}. Occupancy `occ` has three states.
  - EMPTY: `occ`=0.
  - ONE: `occ`=1, head valid.
  - TWO: `occ`=2, head and skid valid.
- `rinc` = `enable` & ~`rempty` & (`occ`!=2).
  - It depends only on registered state and `rempty`, never on `m_ready`.
- push = `rinc`. pop = `m_valid` & `m_ready`. `m_valid` = (`occ`!=0). `m_data`/`m_last` always come from the head entry.
- State transitions:
  - EMPTY: push → ONE.
  - ONE: push & ~pop → TWO. ~push & pop → EMPTY. Push & pop → ONE, and the new word loads into the head.
  - TWO: pop → ONE, and the skid entry moves to the head. No push is possible in TWO.
- Word index `widx` (0..`PKT_LEN`-1):
  - Increments on each push and wraps to 0 after `PKT_LEN`-1.
  - The pushed entry's last bit = (`widx`==`PKT_LEN`-1).
  - `PKT_LEN`=1 means every word has last=1.
- `pkt_cnt` increments on every pop with `m_last`=1 and wraps modulo 2^`CNT_W`.
- Stream rule: while `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` hold stable. `m_valid` never drops without a pop.
- `enable` falling: `rinc` deasserts in the same cycle (combinational). Buffered words drain normally, and `widx` is preserved, so packet framing resumes seamlessly on re-enable.
- Word order: strict FIFO order. No word is dropped or duplicated under any `m_ready` pattern.

## Timing
- Reset (async assert, sync release on `rclk`): `occ`=0, `widx`=0, `pkt_cnt`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `rinc`=0.
  - Reset mid-operation discards buffered words. The FIFO itself is reset by the same `rrst_n`.
- Latency: if `rempty`=0 and `occ`=0 in cycle N, then `rinc`=1 in cycle N and `m_valid`=1 with that word in cycle N+1.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, one word per cycle is sustained in state ONE (push and pop every cycle).
- Back-pressure: `m_ready`=0 fills at most 2 words, then `rinc`=0. After `m_ready` rises, `rinc` reasserts one cycle after the first pop.
- `rempty` asserting in the same cycle as a pop: no push, `occ` decrements. `rinc` is never asserted while `rempty`=1.
- No combinational path runs from `m_ready` to `rinc`. The `m_ready` → internal-state path is registered.

## Test plan
- Reset check: assert `rrst_n`=0 mid-stream with `occ`=2 → all outputs read 0 immediately (async). After release, the first word popped carries `widx`=0 and `pkt_cnt`=0.
- Streaming, `PKT_LEN`=4: write 0x00..0x0B into the FIFO, hold `m_ready`=1.
  - Required: 12 beats in order.
  - `m_last` is high on 0x03, 0x07 and 0x0B only.
  - `pkt_cnt` ends at 3.
  - Steady-state 1 beat per cycle.
- Back-pressure: 8 words queued, `m_ready`=0 for 10 cycles.
  - Exactly 2 `rinc` pulses, then `rinc`=0.
  - `m_data` is stable at the first word throughout.
  - Release `m_ready` → all 8 words arrive in order with no gaps beyond 1 cycle after the release.
- Random `m_ready` (50%) plus random FIFO fill over 1000 words.
  - Scoreboard passes: no loss, no duplication.
  - `m_data` is stable whenever valid and not ready.
  - `rinc`=1 never occurs with `rempty`=1 or `occ`=2.
- `enable` toggle, `PKT_LEN`=4: drop `enable` after word 2 and hold for 5 cycles.
  - Buffered words drain.
  - After re-enable, word 3 (0x03) carries `m_last`=1 and `pkt_cnt` becomes 1.
- Wrap, `CNT_W`=2, `PKT_LEN`=1: stream 5 words → `pkt_cnt` sequence 1, 2, 3, 0, 1.
